// File: rtl/key_fifo_pkg.sv
// Shared constants for the keypad capture FIFO: FSM state codes and
// bit positions of the status/data and control words.
package key_fifo_pkg;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ACK      = 2'd1;
    localparam logic [1:0] WAIT_REL = 2'd2;

    localparam int NE_BIT  = 31;
    localparam int OVF_BIT = 30;
    localparam int CNT_LSB = 8;

    localparam int CTL_FLUSH  = 0;
    localparam int CTL_OVFCLR = 1;
    localparam int CTL_IRQEN  = 2;

endpackage

// File: rtl/key_fifo_sync_fifo.sv
// Generic register-file FIFO with flush; a push while full is accepted
// only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       empty_next
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_ok;
    logic             push_ok;
    logic [CW-1:0]    count_next;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign head    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (flush)
            count_next = '0;
        else
            count_next = count + CW'(push_ok) - CW'(pop_ok);
    end

    assign empty_next = (count_next == '0);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

    // Storage needs no reset: the head is only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push_ok)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/key_fifo.sv
// Keypad scan-code buffer: acknowledges each scanner code, queues it, and
// exposes a CPU status/data word plus a level interrupt.
module key_fifo
    import key_fifo_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int KEY_W      = 5,
    parameter int ACK_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_ready,
    input  logic [KEY_W-1:0] key_in,
    output logic             readn,
    input  logic             bus_rd,
    input  logic             bus_we,
    input  logic [31:0]      bus_wdata,
    output logic [31:0]      rd_data,
    output logic             irq
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [1:0]       state;
    logic [3:0]       ack_cnt;
    logic             overflow;
    logic             irq_en;
    logic             irq_en_next;
    logic             capture;
    logic             flush;
    logic             ovf_set;
    logic [KEY_W-1:0] head;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             empty_next;
    logic             unused_wdata;

    assign unused_wdata = ^bus_wdata[31:3];

    assign capture     = (state == IDLE) & key_ready;
    assign flush       = bus_we & bus_wdata[CTL_FLUSH];
    // A flushed capture is discarded rather than counted as an overflow.
    assign ovf_set     = capture & full & ~(bus_rd & ~empty) & ~flush;
    assign irq_en_next = bus_we ? bus_wdata[CTL_IRQEN] : irq_en;

    sync_fifo #(
        .WIDTH(KEY_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (capture),
        .pop        (bus_rd),
        .flush      (flush),
        .din        (key_in),
        .head       (head),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .empty_next (empty_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            readn    <= 1'b1;
            ack_cnt  <= '0;
            overflow <= 1'b0;
            irq_en   <= 1'b0;
            irq      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (key_ready) begin
                        state   <= ACK;
                        readn   <= 1'b0;
                        ack_cnt <= 4'(ACK_CYCLES);
                    end
                end
                ACK: begin
                    ack_cnt <= ack_cnt - 1'b1;
                    if (ack_cnt == 4'd1) begin
                        readn <= 1'b1;
                        state <= WAIT_REL;
                    end
                end
                WAIT_REL: begin
                    if (!key_ready)
                        state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    readn <= 1'b1;
                end
            endcase

            if (ovf_set)
                overflow <= 1'b1;
            else if (bus_we && bus_wdata[CTL_OVFCLR])
                overflow <= 1'b0;

            irq_en <= irq_en_next;
            irq    <= irq_en_next & ~empty_next;
        end
    end

    always_comb begin
        rd_data                  = '0;
        rd_data[NE_BIT]          = ~empty;
        rd_data[OVF_BIT]         = overflow;
        rd_data[CNT_LSB +: CW]   = count;
        if (!empty)
            rd_data[KEY_W-1:0]   = head;
    end

endmodule

// File: tb/tb_key_fifo.sv
// Scenario-driven self-checking bench for key_fifo; expected codes are
// queued when a key is presented and compared as the CPU pops them.
module tb_key_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_ready;
    logic [4:0]  key_in;
    logic        readn;
    logic        bus_rd;
    logic        bus_we;
    logic [31:0] bus_wdata;
    logic [31:0] rd_data;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [4:0] sb[$];

    key_fifo #(
        .DEPTH(8),
        .KEY_W(5),
        .ACK_CYCLES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_ready (key_ready),
        .key_in    (key_in),
        .readn     (readn),
        .bus_rd    (bus_rd),
        .bus_we    (bus_we),
        .bus_wdata (bus_wdata),
        .rd_data   (rd_data),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    // Runs out the acknowledge from the cycle after capture, then releases the key.
    task automatic finish_ack(output int lows);
        int k;
        lows = 0;
        for (k = 0; k < 40; k++) begin
            if (readn === 1'b1) break;
            lows++;
            tick();
        end
        if (k == 40) begin
            checks++; errors++;
            $display("FAIL ack_timeout: readn=%b required 1 within 40 cycles", readn);
        end
        key_ready = 1'b0;
        tick();
    endtask

    task automatic push_key(input logic [4:0] code, output int lows);
        key_ready = 1'b1;
        key_in    = code;
        tick();
        finish_ack(lows);
    endtask

    task automatic do_pop();
        bus_rd = 1'b1;
        tick();
        bus_rd = 1'b0;
    endtask

    task automatic ctl_write(input logic [31:0] w);
        bus_we    = 1'b1;
        bus_wdata = w;
        tick();
        bus_we    = 1'b0;
        bus_wdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if (readn !== 1'b1) begin errors++; $display("FAIL reset_readn: got %b required 1", readn); end
        checks++;
        if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data: got %h required 00000000", rd_data); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b required 0", irq); end
    endtask

    task automatic test_single_key();
        int lows;
        logic [4:0] exp;
        key_ready = 1'b1;
        key_in    = 5'h13;
        lows = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++;
            if (readn !== ((i == 1 || i == 2) ? 1'b0 : 1'b1)) begin
                errors++;
                $display("FAIL single_readn_cycle%0d: got %b required %b", i, readn, (i == 1 || i == 2) ? 1'b0 : 1'b1);
            end
            if (readn === 1'b0) lows++;
        end
        sb.push_back(5'h13);
        key_ready = 1'b0;
        tick(); tick();
        checks++;
        if (lows != 2) begin errors++; $display("FAIL single_readn_len: got %0d required 2", lows); end
        checks++;
        if (rd_data !== 32'h8000_0113) begin errors++; $display("FAIL single_rd_data: got %h required 80000113", rd_data); end
        exp = sb.pop_front();
        checks++;
        if (rd_data[4:0] !== exp) begin errors++; $display("FAIL single_head: got %h required %h", rd_data[4:0], exp); end
        do_pop();
    endtask

    task automatic test_order();
        int lows;
        logic [4:0] exp;
        for (int i = 1; i <= 3; i++) begin
            push_key(5'(i), lows);
            sb.push_back(5'(i));
        end
        checks++;
        if (rd_data[11:8] !== 4'd3) begin errors++; $display("FAIL order_count_init: got %0d required 3", rd_data[11:8]); end
        for (int i = 0; i < 3; i++) begin
            exp = sb.pop_front();
            checks++;
            if (rd_data[7:0] !== {3'b000, exp}) begin errors++; $display("FAIL order_head%0d: got %h required %h", i, rd_data[7:0], exp); end
            do_pop();
            checks++;
            if (rd_data[11:8] !== 4'(2 - i)) begin errors++; $display("FAIL order_count%0d: got %0d required %0d", i, rd_data[11:8], 2 - i); end
        end
        checks++;
        if (rd_data !== 32'h0) begin errors++; $display("FAIL order_final: got %h required 00000000", rd_data); end
        do_pop();
        checks++;
        if (rd_data !== 32'h0) begin errors++; $display("FAIL order_pop_empty: got %h required 00000000", rd_data); end
    endtask

    task automatic test_overflow();
        int lows;
        for (int i = 0; i < 8; i++) begin
            push_key(5'h10 + 5'(i), lows);
            sb.push_back(5'h10 + 5'(i));
        end
        checks++;
        if (rd_data[31:30] !== 2'b10 || rd_data[11:8] !== 4'd8) begin
            errors++; $display("FAIL ovf_full_status: got %h required ne=1 ovf=0 count=8", rd_data);
        end
        push_key(5'h1F, lows);
        checks++;
        if (lows != 2) begin errors++; $display("FAIL ovf_readn_len: got %0d required 2", lows); end
        checks++;
        if (rd_data[30] !== 1'b1) begin errors++; $display("FAIL ovf_flag_set: got %b required 1", rd_data[30]); end
        checks++;
        if (rd_data[11:8] !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d required 8", rd_data[11:8]); end
        ctl_write(32'h2);
        checks++;
        if (rd_data[30] !== 1'b0) begin errors++; $display("FAIL ovf_flag_clear: got %b required 0", rd_data[30]); end
    endtask

    task automatic test_push_pop_full();
        int lows;
        logic [4:0] exp;
        exp = sb.pop_front();
        checks++;
        if (rd_data[4:0] !== exp) begin errors++; $display("FAIL pp_head: got %h required %h", rd_data[4:0], exp); end
        key_ready = 1'b1;
        key_in    = 5'h07;
        bus_rd    = 1'b1;
        tick();
        bus_rd    = 1'b0;
        sb.push_back(5'h07);
        finish_ack(lows);
        checks++;
        if (rd_data[11:8] !== 4'd8 || rd_data[30] !== 1'b0) begin
            errors++; $display("FAIL pp_count: got count=%0d ovf=%b required count=8 ovf=0", rd_data[11:8], rd_data[30]);
        end
        for (int i = 0; i < 8; i++) begin
            exp = sb.pop_front();
            checks++;
            if (rd_data[4:0] !== exp) begin errors++; $display("FAIL pp_drain%0d: got %h required %h", i, rd_data[4:0], exp); end
            do_pop();
        end
        checks++;
        if (rd_data !== 32'h0) begin errors++; $display("FAIL pp_empty: got %h required 00000000", rd_data); end
    endtask

    task automatic test_irq_flush();
        int lows;
        logic [4:0] exp;
        ctl_write(32'h4);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_empty: got %b required 0", irq); end
        key_ready = 1'b1;
        key_in    = 5'h09;
        tick();
        sb.push_back(5'h09);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_after_push: got %b required 1", irq); end
        finish_ack(lows);
        exp = sb.pop_front();
        checks++;
        if (rd_data[4:0] !== exp) begin errors++; $display("FAIL irq_head: got %h required %h", rd_data[4:0], exp); end
        do_pop();
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_pop: got %b required 0", irq); end
        push_key(5'h0A, lows);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_refill: got %b required 1", irq); end
        key_ready = 1'b1;
        key_in    = 5'h15;
        bus_we    = 1'b1;
        bus_wdata = 32'h5;
        tick();
        bus_we    = 1'b0;
        bus_wdata = '0;
        checks++;
        if (rd_data !== 32'h0) begin errors++; $display("FAIL flush_rd_data: got %h required 00000000", rd_data); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL flush_irq: got %b required 0", irq); end
        finish_ack(lows);
        checks++;
        if (lows != 2) begin errors++; $display("FAIL flush_readn_len: got %0d required 2", lows); end
        checks++;
        if (rd_data !== 32'h0) begin errors++; $display("FAIL flush_discard: got %h required 00000000", rd_data); end
    endtask

    task automatic test_reset_mid_ack();
        int lows;
        ctl_write(32'h4);
        push_key(5'h0C, lows);
        key_ready = 1'b1;
        key_in    = 5'h11;
        tick();
        checks++;
        if (readn !== 1'b0) begin errors++; $display("FAIL rstack_in_ack: got %b required 0", readn); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (readn !== 1'b1 || rd_data !== 32'h0 || irq !== 1'b0) begin
            errors++; $display("FAIL rstack_state: got readn=%b rd_data=%h irq=%b required 1 00000000 0", readn, rd_data, irq);
        end
        tick();
        sb.push_back(5'h11);
        checks++;
        if (readn !== 1'b0) begin errors++; $display("FAIL rstack_recapture: got %b required 0", readn); end
        checks++;
        if (rd_data !== 32'h8000_0111) begin errors++; $display("FAIL rstack_rd_data: got %h required 80000111", rd_data); end
        finish_ack(lows);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL rstack_irq_en_cleared: got %b required 0", irq); end
        checks++;
        if (rd_data[4:0] !== sb[0]) begin errors++; $display("FAIL rstack_head: got %h required %h", rd_data[4:0], sb[0]); end
        void'(sb.pop_front());
        do_pop();
        checks++;
        if (rd_data !== 32'h0) begin errors++; $display("FAIL rstack_empty: got %h required 00000000", rd_data); end
    endtask

    initial begin
        rst       = 1'b1;
        key_ready = 1'b0;
        key_in    = '0;
        bus_rd    = 1'b0;
        bus_we    = 1'b0;
        bus_wdata = '0;
        test_reset();
        test_single_key();
        test_order();
        test_overflow();
        test_push_pop_full();
        test_irq_flush();
        test_reset_mid_ack();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
